// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Holds the boot/exception vectors, pc_src encodings and the IF/ID record.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_PC   = 32'hBFC0_0380;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_EXC  = 2'b10;
    localparam logic [1:0] PCSRC_SKIP = 2'b11;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
        logic        adel;
    } if_id_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register: kill (flush or boot edge) beats stall beats capture.
// A misaligned fetch is captured with a NOP word and the address-error flag set.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        kill,
    input  logic        stall,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        if_adel,
    output if_id_t      id_q
);

    if_id_t id_r;
    if_id_t id_nxt_s;

    // Next IF/ID contents; a kill leaves pc/pc4 untouched
    always_comb begin
        id_nxt_s = id_r;
        if (kill) begin
            id_nxt_s.inst  = NOP;
            id_nxt_s.valid = 1'b0;
            id_nxt_s.adel  = 1'b0;
        end else if (stall) begin
            id_nxt_s = id_r;
        end else begin
            id_nxt_s.pc    = if_pc;
            id_nxt_s.pc4   = if_pc + 32'd4;
            id_nxt_s.inst  = if_adel ? NOP : if_inst;
            id_nxt_s.valid = 1'b1;
            id_nxt_s.adel  = if_adel;
        end
    end

    // IF/ID storage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_r.pc    <= RESET_PC;
            id_r.pc4   <= RESET_PC + 32'd4;
            id_r.inst  <= NOP;
            id_r.valid <= 1'b0;
            id_r.adel  <= 1'b0;
        end else begin
            id_r <= id_nxt_s;
        end
    end

    assign id_q = id_r;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: fetch PC, synchronous SRAM request and IF/ID register.
// inst_sram_addr is combinational so the SRAM samples the next PC on the same edge pc_q loads it.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC,
    parameter logic [31:0] EXC_PC   = if_stage_pkg::EXC_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_adel
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic [31:0]  pc_r;
    logic         misal_r;
    logic [31:0]  next_pc_s;
    logic         fetch_ok_s;
    logic         kill_s;
    if_id_t       id_s;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: BOOT lasts exactly one edge
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            BOOT:    state_nxt_s = RUN;
            RUN:     state_nxt_s = RUN;
            default: state_nxt_s = BOOT;
        endcase
    end

    // Output decode: next fetch address; stall re-reads pc_q so rdata stays stable
    always_comb begin
        next_pc_s  = RESET_PC;
        fetch_ok_s = 1'b0;
        case (state_r)
            BOOT: begin
                next_pc_s  = RESET_PC;
                fetch_ok_s = 1'b0;
            end
            RUN: begin
                fetch_ok_s = 1'b1;
                if (stall) begin
                    next_pc_s = pc_r;
                end else begin
                    case (pc_src)
                        PCSRC_SEQ:  next_pc_s = pc_r + 32'd4;
                        PCSRC_BR:   next_pc_s = branch_target;
                        PCSRC_EXC:  next_pc_s = EXC_PC;
                        PCSRC_SKIP: next_pc_s = pc_r + 32'd8;
                        default:    next_pc_s = pc_r + 32'd4;
                    endcase
                end
            end
            default: begin
                next_pc_s  = RESET_PC;
                fetch_ok_s = 1'b0;
            end
        endcase
    end

    // Fetch PC and its misalignment flag advance together
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_r    <= RESET_PC;
            misal_r <= 1'b0;
        end else if ((state_r == RUN) && !stall) begin
            pc_r    <= next_pc_s;
            misal_r <= is_misaligned(next_pc_s);
        end else begin
            pc_r    <= pc_r;
            misal_r <= misal_r;
        end
    end

    assign inst_sram_addr = {next_pc_s[31:2], 2'b00};
    assign inst_sram_en   = !is_misaligned(next_pc_s);
    assign inst_sram_wen  = 4'b0000;

    // The boot edge has no word on rdata yet, so it is treated like a flush
    assign kill_s = flush || !fetch_ok_s;

    if_id_reg #(
        .RESET_PC (RESET_PC)
    ) u_if_id_reg (
        .clk     (clk),
        .resetn  (resetn),
        .kill    (kill_s),
        .stall   (stall),
        .if_pc   (pc_r),
        .if_inst (inst_sram_rdata),
        .if_adel (misal_r),
        .id_q    (id_s)
    );

    assign id_pc    = id_s.pc;
    assign id_pc4   = id_s.pc4;
    assign id_inst  = id_s.inst;
    assign id_valid = id_s.valid;
    assign id_adel  = id_s.adel;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, mid-run async reset, then random
// stimulus checked against a program-order fetch model.
module tb_if_stage;

    localparam logic [31:0] R_PC = 32'hBFC0_0000;
    localparam logic [31:0] E_PC = 32'hBFC0_0380;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        flush;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_adel;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .flush           (flush),
        .pc_src          (pc_src),
        .branch_target   (branch_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .id_pc           (id_pc),
        .id_pc4          (id_pc4),
        .id_inst         (id_inst),
        .id_valid        (id_valid),
        .id_adel         (id_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word stored at an address: distinct from the address itself
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    // Synchronous instruction SRAM
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= word_at(inst_sram_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_id(input logic [31:0] e_pc, input logic e_valid, input logic e_adel);
        logic [31:0] e_inst;
        e_inst = (e_valid && !e_adel) ? word_at({e_pc[31:2], 2'b00}) : 32'h0;
        chk("id_pc",    id_pc,              e_pc);
        chk("id_pc4",   id_pc4,             e_pc + 32'd4);
        chk("id_inst",  id_inst,            e_inst);
        chk("id_valid", {31'd0, id_valid},  {31'd0, e_valid});
        chk("id_adel",  {31'd0, id_adel},   {31'd0, e_adel});
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic [1:0]  pc_src;
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic        exp_en;
        logic [31:0] exp_id_pc;
        logic        exp_valid;
        logic        exp_adel;
    } vec_t;

    vec_t vecs[18];

    // Reference model state: instruction currently in IF, plus IF/ID contents
    logic        m_boot;
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_id_pc;
    logic        m_id_valid;
    logic        m_id_adel;

    initial begin
        logic [31:0] nxt;
        int          r;

        resetn = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        pc_src = 2'b00;
        branch_target = 32'h0;
        inst_sram_rdata = 32'h0;

        //        stall flush src    target        addr          en    id_pc         val   adel
        vecs[0]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'hBFC00000, 1'b1, 32'hBFC00000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'hBFC00004, 1'b1, 32'hBFC00000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'hBFC00008, 1'b1, 32'hBFC00000, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'b00, 32'h0,        32'hBFC00008, 1'b1, 32'hBFC00004, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 32'h0,        32'hBFC00008, 1'b1, 32'hBFC00004, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'b00, 32'h0,        32'hBFC00008, 1'b1, 32'hBFC00004, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 2'b01, 32'h80001000, 32'h80001000, 1'b1, 32'hBFC00004, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h80001004, 1'b1, 32'hBFC00008, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 2'b01, 32'h80001002, 32'h80001000, 1'b0, 32'h80001000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'b01, 32'h80002000, 32'h80002000, 1'b1, 32'h80001004, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'b10, 32'h0,        32'hBFC00380, 1'b1, 32'h80001002, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'hBFC00384, 1'b1, 32'h80001002, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 2'b10, 32'h0,        32'hBFC00384, 1'b1, 32'hBFC00380, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 2'b10, 32'h0,        32'hBFC00380, 1'b1, 32'hBFC00380, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 2'b01, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1, 32'hBFC00384, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h00000000, 1'b1, 32'hBFC00380, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 2'b11, 32'h0,        32'h00000008, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0000000C, 1'b1, 32'h00000000, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_addr", inst_sram_addr, R_PC);
        chk("rst_en",   {31'd0, inst_sram_en}, 32'd1);
        chk("rst_wen",  {28'd0, inst_sram_wen}, 32'd0);
        chk_id(R_PC, 1'b0, 1'b0);
        resetn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            stall = vecs[i].stall;
            flush = vecs[i].flush;
            pc_src = vecs[i].pc_src;
            branch_target = vecs[i].target;
            #1;
            chk($sformatf("v%0d_addr", i), inst_sram_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_en", i), {31'd0, inst_sram_en}, {31'd0, vecs[i].exp_en});
            chk_id(vecs[i].exp_id_pc, vecs[i].exp_valid, vecs[i].exp_adel);
            @(negedge clk);
        end

        // Asynchronous reset mid-run takes effect without a clock edge
        stall = 1'b0;
        flush = 1'b0;
        pc_src = 2'b00;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_addr", inst_sram_addr, R_PC);
        chk("arst_en",   {31'd0, inst_sram_en}, 32'd1);
        chk_id(R_PC, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        m_boot = 1'b1;
        m_pc = R_PC;
        m_mis = 1'b0;
        m_id_pc = R_PC;
        m_id_valid = 1'b0;
        m_id_adel = 1'b0;

        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 19);
            pc_src = (r < 12) ? 2'b00 : (r < 15) ? 2'b01 : (r < 17) ? 2'b10 : 2'b11;
            branch_target = $urandom;
            if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;

            if (m_boot)             nxt = R_PC;
            else if (stall)         nxt = m_pc;
            else if (pc_src == 2'b00) nxt = m_pc + 32'd4;
            else if (pc_src == 2'b01) nxt = branch_target;
            else if (pc_src == 2'b10) nxt = E_PC;
            else                    nxt = m_pc + 32'd8;

            #1;
            chk("rnd_addr", inst_sram_addr, nxt & 32'hFFFF_FFFC);
            chk("rnd_en", {31'd0, inst_sram_en}, {31'd0, (nxt % 4) == 0});
            chk_id(m_id_pc, m_id_valid, m_id_adel);

            if (m_boot || flush) begin
                m_id_valid = 1'b0;
                m_id_adel = 1'b0;
            end else if (!stall) begin
                m_id_pc = m_pc;
                m_id_valid = 1'b1;
                m_id_adel = m_mis;
            end
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (!stall) begin
                m_pc = nxt;
                m_mis = (nxt % 4) != 0;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
